// File: rtl/conv_line_buffer_pkg.sv
// Shared constants for the convolution line buffer and its pe_wrapper consumer.
// Contents: default lane/bus widths matching pe_wrapper dataIn packing, the
// FILL/STREAM state encoding, and a lane-offset helper for packed column buses.
package conv_line_buffer_pkg;

    localparam int unsigned KERNEL_SIZE_DEF = 3;
    localparam int unsigned LANE_W          = 8;
    localparam int unsigned BUS_W           = LANE_W * KERNEL_SIZE_DEF;

    localparam int unsigned STATE_W = 1;
    localparam logic [STATE_W-1:0] ST_FILL   = 1'b0;
    localparam logic [STATE_W-1:0] ST_STREAM = 1'b1;

    // Bit offset of lane 'lane' in a packed column bus (lane 0 at the LSBs).
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned lane_w);
        return lane * lane_w;
    endfunction

endpackage

// File: rtl/conv_line_buffer_line_ram.sv
// One row of pixel history for the line buffer.
// Ports: clk; we/addr/wdata single write port; rdata combinational read at addr,
// returning the value stored before any write on the same edge (read-before-write).
module conv_line_buffer_line_ram #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    output logic [DATA_WIDTH-1:0]      rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Storage is never cleared: every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/conv_line_buffer.sv
// Raster-order pixel stream to KERNEL_SIZE-tall column vectors for pe_wrapper.
// Ports: clk, rstn (sync, active-low); s_valid/s_ready/s_data pixel input;
// m_valid/m_ready/m_data column output (lane j at [j*DATA_WIDTH +: DATA_WIDTH],
// lane 0 = oldest row); m_last_col marks the row's last column, m_last the
// frame's last column; frame_done pulses the cycle after the m_last handshake.
module conv_line_buffer
    import conv_line_buffer_pkg::*;
#(
    parameter int unsigned KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int unsigned DATA_WIDTH  = LANE_W,
    parameter int unsigned IMG_WIDTH   = 16,
    parameter int unsigned IMG_HEIGHT  = 16
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_WIDTH-1:0]             s_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [DATA_WIDTH*KERNEL_SIZE-1:0] m_data,
    output logic                              m_last_col,
    output logic                              m_last,
    output logic                              frame_done
);

    localparam int unsigned COL_W  = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W  = $clog2(IMG_HEIGHT);
    localparam int unsigned NBUF   = KERNEL_SIZE - 1;
    localparam int unsigned MBUS_W = DATA_WIDTH * KERNEL_SIZE;

    localparam logic [COL_W-1:0] COL_END      = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_END      = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_FILL_END = ROW_W'(KERNEL_SIZE - 2);

    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic               m_valid_q, m_valid_d;
    logic [MBUS_W-1:0]  m_data_q, m_data_d;
    logic               m_last_col_q, m_last_col_d;
    logic               m_last_q, m_last_d;
    logic               frame_done_q, frame_done_d;

    logic                  accept;
    logic [MBUS_W-1:0]     cand;
    logic [DATA_WIDTH-1:0] rd_data [NBUF];
    logic [DATA_WIDTH-1:0] wr_data [NBUF];

    // Output register can drain and refill in one cycle, so ready only drops on a stall.
    assign s_ready = !m_valid_q || m_ready;
    assign accept  = s_valid && s_ready;

    // Row history shifts one buffer toward lane 0 on every accept; newest row enters at the top.
    for (genvar r = 0; r < NBUF; r++) begin : g_lb
        if (r < NBUF - 1) begin : g_shift
            assign wr_data[r] = rd_data[r+1];
        end else begin : g_head
            assign wr_data[r] = s_data;
        end

        conv_line_buffer_line_ram #(
            .DEPTH      (IMG_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_ram (
            .clk   (clk),
            .we    (accept),
            .addr  (col_q),
            .wdata (wr_data[r]),
            .rdata (rd_data[r])
        );
    end

    // Candidate column: pre-write buffer contents plus the incoming pixel as the newest lane.
    for (genvar j = 0; j < NBUF; j++) begin : g_lane
        assign cand[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH] = rd_data[j];
    end
    assign cand[lane_lsb(NBUF, DATA_WIDTH) +: DATA_WIDTH] = s_data;

    // Next-state: raster counters, FILL/STREAM sequencing and the output register.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        state_d      = state_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_last_col_d = m_last_col_q;
        m_last_d     = m_last_q;
        frame_done_d = 1'b0;

        if (m_valid_q && m_ready) begin
            m_valid_d    = 1'b0;
            frame_done_d = m_last_q;
        end

        if (accept) begin
            if (col_q == COL_END) begin
                col_d = '0;
                if (row_q == ROW_END) begin
                    row_d   = '0;
                    state_d = ST_FILL;
                end else begin
                    row_d = row_q + ROW_W'(1);
                    if ((state_q == ST_FILL) && (row_q == ROW_FILL_END)) begin
                        state_d = ST_STREAM;
                    end
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end

            if (state_q == ST_STREAM) begin
                m_valid_d    = 1'b1;
                m_data_d     = cand;
                m_last_col_d = (col_q == COL_END);
                m_last_d     = (col_q == COL_END) && (row_q == ROW_END);
            end
        end
    end

    // State register with synchronous active-low reset; a pending column is dropped.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            col_q        <= '0;
            row_q        <= '0;
            state_q      <= ST_FILL;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_col_q <= 1'b0;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            state_q      <= state_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_col_q <= m_last_col_d;
            m_last_q     <= m_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last_col = m_last_col_q;
    assign m_last     = m_last_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_line_buffer.sv
// Directed bench: a 3x4x4 instance for streaming/stall/gap/reset/frame-boundary
// cases and a 3x2x3 minimum-size instance. Inputs change on the falling edge,
// outputs are sampled 1ns later.
module tb_conv_line_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        s_valid, s_ready, m_valid, m_ready, m_last_col, m_last, frame_done;
    logic [7:0]  s_data;
    logic [23:0] m_data;

    logic        s2_valid, s2_ready, m2_valid, m2_ready, m2_last_col, m2_last, frame_done2;
    logic [7:0]  s2_data;
    logic [23:0] m2_data;

    conv_line_buffer #(.KERNEL_SIZE(3), .DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last_col(m_last_col),
        .m_last(m_last), .frame_done(frame_done));

    conv_line_buffer #(.KERNEL_SIZE(3), .DATA_WIDTH(8), .IMG_WIDTH(2), .IMG_HEIGHT(3)) dut_s (
        .clk(clk), .rstn(rstn), .s_valid(s2_valid), .s_ready(s2_ready), .s_data(s2_data),
        .m_valid(m2_valid), .m_ready(m2_ready), .m_data(m2_data), .m_last_col(m2_last_col),
        .m_last(m2_last), .frame_done(frame_done2));

    typedef struct {
        logic [7:0]  pix;      // pixel whose accept produces this column
        logic [23:0] data;     // {lane2, lane1, lane0}
        bit          lc;
        bit          last;
    } vec_t;

    vec_t tab [8];

    int n_checks = 0;
    int n_errors = 0;

    logic [23:0] cq [$];
    bit          lcq [$];
    bit          lq [$];
    logic [23:0] cq2 [$];
    bit          lcq2 [$];
    bit          lq2 [$];

    int          rdy_mode = 0;
    int          rdy_phase = 0;
    bit          acc1, acc2;
    bit          fd_exp = 0, fd_exp2 = 0;
    int          fd_count = 0, fd_count2 = 0;
    bit          stalled_prev = 0;
    logic [23:0] prev_data;
    bit          prev_lc, prev_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive m_ready, sample 1ns later, log handshakes, advance to next falling edge.
    task automatic tick();
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((rdy_phase % 4) == 0) || ((rdy_phase % 4) == 3);
            default: m_ready = 1'b0;
        endcase
        rdy_phase++;
        #1;
        acc1 = s_valid && s_ready;
        acc2 = s2_valid && s2_ready;
        if (rstn) begin
            chk("frame_done", 32'(frame_done), 32'(fd_exp));
            chk("frame_done_small", 32'(frame_done2), 32'(fd_exp2));
            if (frame_done)  fd_count++;
            if (frame_done2) fd_count2++;
            if (rdy_mode == 1) chk("s_ready_vs_stall", 32'(s_ready), 32'(!(m_valid && !m_ready)));
            if (stalled_prev) begin
                chk("stall_m_valid", 32'(m_valid), 32'd1);
                chk("stall_m_data", 32'(m_data), 32'(prev_data));
                chk("stall_m_last_col", 32'(m_last_col), 32'(prev_lc));
                chk("stall_m_last", 32'(m_last), 32'(prev_last));
            end
            if (m_valid && m_ready) begin
                cq.push_back(m_data); lcq.push_back(m_last_col); lq.push_back(m_last);
            end
            if (m2_valid && m2_ready) begin
                cq2.push_back(m2_data); lcq2.push_back(m2_last_col); lq2.push_back(m2_last);
            end
        end
        stalled_prev = rstn && m_valid && !m_ready;
        prev_data    = m_data;
        prev_lc      = m_last_col;
        prev_last    = m_last;
        fd_exp       = rstn && m_valid && m_ready && m_last;
        fd_exp2      = rstn && m2_valid && m2_ready && m2_last;
        @(negedge clk);
    endtask

    task automatic send1(input logic [7:0] d, output int nt);
        s_valid = 1'b1;
        s_data  = d;
        nt = 0;
        acc1 = 1'b0;
        while (!acc1 && nt < 20) begin
            tick();
            nt++;
        end
        if (!acc1) chk("send_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
    endtask

    task automatic send2(input logic [7:0] d);
        int nt = 0;
        s2_valid = 1'b1;
        s2_data  = d;
        acc2 = 1'b0;
        while (!acc2 && nt < 20) begin
            tick();
            nt++;
        end
        if (!acc2) chk("send_small_timeout", 32'd0, 32'd1);
        s2_valid = 1'b0;
    endtask

    task automatic send_range(input int base, input int first, input int last);
        int nt;
        for (int p = first; p <= last; p++) send1(8'(base + p), nt);
    endtask

    // Let the output register empty, then one more cycle so frame_done is sampled.
    task automatic drain();
        int n = 0;
        s_valid = 1'b0;
        while (m_valid && n < 20) begin
            tick();
            n++;
        end
        if (m_valid) chk("drain_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic clear_log();
        cq.delete(); lcq.delete(); lq.delete();
        fd_count = 0;
    endtask

    task automatic compare_cols(input string name, input int qoff, input int poff);
        logic [23:0] exp;
        for (int i = 0; i < 8; i++) begin
            exp = tab[i].data + 24'(poff) * 24'h010101;
            if (qoff + i >= cq.size()) begin
                chk({name, "_missing"}, 32'(cq.size()), 32'(qoff + i + 1));
            end else begin
                chk({name, "_data"}, 32'(cq[qoff+i]), 32'(exp));
                chk({name, "_last_col"}, 32'(lcq[qoff+i]), 32'(tab[i].lc));
                chk({name, "_last"}, 32'(lq[qoff+i]), 32'(tab[i].last));
            end
        end
    endtask

    initial begin
        int nt;

        tab[0] = '{8'd8,  24'h080400, 1'b0, 1'b0};
        tab[1] = '{8'd9,  24'h090501, 1'b0, 1'b0};
        tab[2] = '{8'd10, 24'h0a0602, 1'b0, 1'b0};
        tab[3] = '{8'd11, 24'h0b0703, 1'b1, 1'b0};
        tab[4] = '{8'd12, 24'h0c0804, 1'b0, 1'b0};
        tab[5] = '{8'd13, 24'h0d0905, 1'b0, 1'b0};
        tab[6] = '{8'd14, 24'h0e0a06, 1'b0, 1'b0};
        tab[7] = '{8'd15, 24'h0f0b07, 1'b1, 1'b1};

        rstn = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        s2_valid = 1'b0; s2_data = '0; m2_ready = 1'b1;
        @(negedge clk);
        tick(); tick();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_last_col", 32'(m_last_col), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        rstn = 1'b1;
        tick();
        chk("post_rst_m_valid", 32'(m_valid), 32'd0);
        chk("post_rst_s_ready", 32'(s_ready), 32'd1);

        // Basic frame: no output while filling, then one column per pixel with 1-cycle latency.
        clear_log();
        for (int p = 0; p < 8; p++) begin
            send1(8'(p), nt);
            chk("fill_no_m_valid", 32'(m_valid), 32'd0);
        end
        for (int v = 0; v < 8; v++) begin
            send1(tab[v].pix, nt);
            chk("vec_m_valid", 32'(m_valid), 32'd1);
            chk("vec_m_data", 32'(m_data), 32'(tab[v].data));
            chk("vec_m_last_col", 32'(m_last_col), 32'(tab[v].lc));
            chk("vec_m_last", 32'(m_last), 32'(tab[v].last));
        end
        drain();
        chk("t1_col_count", 32'(cq.size()), 32'd8);
        chk("t1_frame_done_count", 32'(fd_count), 32'd1);

        // Backpressure with ready pattern 1,0,0,1.
        clear_log();
        rdy_mode = 1; rdy_phase = 0;
        send_range(0, 0, 15);
        drain();
        rdy_mode = 0;
        chk("t2_col_count", 32'(cq.size()), 32'd8);
        compare_cols("t2", 0, 0);
        chk("t2_frame_done_count", 32'(fd_count), 32'd1);

        // Back-to-back frames; the second frame's first pixel is accepted without a bubble.
        clear_log();
        send_range(0, 0, 15);
        send1(8'd100, nt);
        chk("t3_boundary_ticks", 32'(nt), 32'd1);
        send_range(100, 1, 15);
        drain();
        chk("t3_col_count", 32'(cq.size()), 32'd16);
        compare_cols("t3_f0", 0, 0);
        compare_cols("t3_f1", 8, 100);
        chk("t3_frame_done_count", 32'(fd_count), 32'd2);

        // Input gap of 3 cycles between pixels 9 and 10.
        clear_log();
        send_range(0, 0, 9);
        for (int g = 0; g < 3; g++) begin
            tick();
            chk("t4_gap_m_valid", 32'(m_valid), 32'd0);
        end
        send_range(0, 10, 15);
        drain();
        chk("t4_col_count", 32'(cq.size()), 32'd8);
        compare_cols("t4", 0, 0);

        // Reset with a column pending, then a fresh frame.
        clear_log();
        send_range(0, 0, 9);
        chk("t5_pending_m_valid", 32'(m_valid), 32'd1);
        rstn = 1'b0; rdy_mode = 2;
        tick();
        rstn = 1'b1; rdy_mode = 0;
        chk("t5_rst_m_valid", 32'(m_valid), 32'd0);
        chk("t5_rst_m_data", 32'(m_data), 32'd0);
        chk("t5_rst_s_ready", 32'(s_ready), 32'd1);
        clear_log();
        send_range(0, 0, 7);
        chk("t5_log_empty_before_p8", 32'(cq.size()), 32'd0);
        send_range(0, 8, 15);
        drain();
        chk("t5_col_count", 32'(cq.size()), 32'd8);
        compare_cols("t5", 0, 0);
        chk("t5_frame_done_count", 32'(fd_count), 32'd1);

        // Minimum configuration K=3, W=2, H=3.
        cq2.delete(); lcq2.delete(); lq2.delete(); fd_count2 = 0;
        for (int p = 0; p < 6; p++) send2(8'(p));
        for (int i = 0; i < 4; i++) tick();
        chk("t6_col_count", 32'(cq2.size()), 32'd2);
        if (cq2.size() >= 2) begin
            chk("t6_col0_data", 32'(cq2[0]), 32'h040200);
            chk("t6_col0_last_col", 32'(lcq2[0]), 32'd0);
            chk("t6_col0_last", 32'(lq2[0]), 32'd0);
            chk("t6_col1_data", 32'(cq2[1]), 32'h050301);
            chk("t6_col1_last_col", 32'(lcq2[1]), 32'd1);
            chk("t6_col1_last", 32'(lq2[1]), 32'd1);
        end
        chk("t6_frame_done_count", 32'(fd_count2), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
